// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule: expands cipherKey into w[0..4*(Nr+1)-1], one word per clock.
// Optional round-key read port enabled by defining KEYEXP_ROUND_READ_EN.
module key_expansion_seq #(
  parameter  int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic                     clks,
  input  logic                     reset,
  input  logic                     start,
  input  logic [0:Nk*32-1]         cipherKey,
  output logic                     busy,
  output logic                     keys_valid,
`ifdef KEYEXP_ROUND_READ_EN
  input  logic [3:0]               rd_round,
  output logic [0:127]             rd_key,
`endif
  output logic [0:128*(Nr+1)-1]    keys
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state_r;
  logic [IW-1:0] i_r;
  logic [2:0]  phase_r;
  logic [7:0]  rcon_r;
  logic [31:0] w_r [0:NW-1];
  logic [31:0] prev_s;
  logic [31:0] back_s;
  logic [31:0] temp_s;
  logic [31:0] next_word_s;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    base = 11'd2047 - {x, 3'b000};
    return SBOX_TABLE[base -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Next schedule word from w[i-1] and w[i-Nk]; phase_r tracks i mod Nk
  always_comb begin
    prev_s = 32'h0;
    back_s = 32'h0;
    for (int k = 0; k < NW; k++) begin
      prev_s = (k + 1 == int'(i_r))  ? w_r[k] : prev_s;
      back_s = (k + Nk == int'(i_r)) ? w_r[k] : back_s;
    end
    if (phase_r == 3'd0) begin
      temp_s = sub_word(rot_word(prev_s)) ^ {rcon_r, 24'h000000};
    end else if (Nk == 8 && phase_r == 3'd4) begin
      temp_s = sub_word(prev_s);
    end else begin
      temp_s = prev_s;
    end
    next_word_s = back_s ^ temp_s;
  end

  // Control FSM, word index, round constant and schedule storage
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      keys_valid <= 1'b0;
      i_r        <= '0;
      phase_r    <= 3'd0;
      rcon_r     <= 8'h01;
      for (int k = 0; k < NW; k++) w_r[k] <= 32'h0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < Nk; k++) w_r[k] <= cipherKey[32*k +: 32];
            i_r        <= IW'(Nk);
            phase_r    <= 3'd0;
            rcon_r     <= 8'h01;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state_r    <= EXPAND;
          end else begin
            state_r <= state_r;
          end
        end
        EXPAND: begin
          for (int k = 0; k < NW; k++) begin
            if (int'(i_r) == k) w_r[k] <= next_word_s;
          end
          phase_r <= (int'(phase_r) == Nk - 1) ? 3'd0 : phase_r + 3'd1;
          // Advance rcon only if another i mod Nk == 0 word follows, so it stops at its last used value
          if (phase_r == 3'd0 && int'(i_r) + Nk < NW) begin
            rcon_r <= xtime(rcon_r);
          end
          if (int'(i_r) == NW - 1) begin
            state_r    <= DONE;
            busy       <= 1'b0;
            keys_valid <= 1'b1;
          end else begin
            i_r <= i_r + IW'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          busy       <= 1'b0;
          keys_valid <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_keys
    assign keys[32*g +: 32] = w_r[g];
  end

`ifdef KEYEXP_ROUND_READ_EN
  // Round-key read port: words 4r..4r+3, zero beyond the last round
  always_comb begin
    rd_key = 128'h0;
    for (int r = 0; r <= Nr; r++) begin
      rd_key = (int'(rd_round) == r) ? {w_r[4*r], w_r[4*r+1], w_r[4*r+2], w_r[4*r+3]} : rd_key;
    end
  end
`else
  // Without the read port, consumers slice the keys bus directly.
`endif

endmodule

// File: tb/tb_key_expansion_seq.sv
// Directed bench for key_expansion_seq: FIPS-197 vectors for Nk=4/6/8 plus control robustness.
module tb_key_expansion_seq;

  localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] SEQ_KEY4 = 128'h000102030405060708090a0b0c0d0e0f;

  logic clks = 1'b0;
  always #5 clks = ~clks;

  logic reset, start4, start6, start8;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic busy4, busy6, busy8, kv4, kv6, kv8;
  logic [0:1407] keys4;
  logic [0:1663] keys6;
  logic [0:1919] keys8;
`ifdef KEYEXP_ROUND_READ_EN
  logic [0:127] rd4, rd6, rd8;
`endif

  int checks = 0;
  int fails  = 0;

  key_expansion_seq #(.Nk(4)) dut4 (
    .clks(clks), .reset(reset), .start(start4), .cipherKey(key4),
    .busy(busy4), .keys_valid(kv4),
`ifdef KEYEXP_ROUND_READ_EN
    .rd_round(4'd0), .rd_key(rd4),
`endif
    .keys(keys4));

  key_expansion_seq #(.Nk(6)) dut6 (
    .clks(clks), .reset(reset), .start(start6), .cipherKey(key6),
    .busy(busy6), .keys_valid(kv6),
`ifdef KEYEXP_ROUND_READ_EN
    .rd_round(4'd0), .rd_key(rd6),
`endif
    .keys(keys6));

  key_expansion_seq #(.Nk(8)) dut8 (
    .clks(clks), .reset(reset), .start(start8), .cipherKey(key8),
    .busy(busy8), .keys_valid(kv8),
`ifdef KEYEXP_ROUND_READ_EN
    .rd_round(4'd0), .rd_key(rd8),
`endif
    .keys(keys8));

  task automatic pulse(input int sel);
    case (sel)
      4:       start4 = 1'b1;
      6:       start6 = 1'b1;
      default: start8 = 1'b1;
    endcase
    @(posedge clks); #1;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
  endtask

  task automatic wait_valid(input int sel, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge clks); #1;
      n++;
      v = (sel == 4) ? kv4 : (sel == 6) ? kv6 : kv8;
    end while (!v && n < 300);
    if (!v) n = -1;
  endtask

  task automatic test_reset;
    reset = 1'b0; start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
    #1 reset = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", kv4); end
    checks++; if (keys4 !== 1408'h0) begin fails++; $display("FAIL reset_keys: got nonzero expected 0"); end
    @(posedge clks); #1 reset = 1'b0;
    key4 = FIPS_KEY;
    pulse(4);
    repeat (5) @(posedge clks);
    #2;
    checks++; if (busy4 !== 1'b1) begin fails++; $display("FAIL busy_during_expand: got %b expected 1", busy4); end
    reset = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL async_reset_busy: got %b expected 0", busy4); end
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL async_reset_valid: got %b expected 0", kv4); end
    checks++; if (keys4 !== 1408'h0) begin fails++; $display("FAIL async_reset_keys: got nonzero expected 0"); end
    @(posedge clks); #1 reset = 1'b0;
  endtask

  task automatic test_fips_key;
    int n;
    key4 = FIPS_KEY;
    pulse(4);
    checks++; if (busy4 !== 1'b1) begin fails++; $display("FAIL fips_busy: got %b expected 1", busy4); end
    key4 = 128'hffffffffffffffffffffffffffffffff;
    wait_valid(4, n);
    checks++; if (n !== 40) begin fails++; $display("FAIL fips_latency: got %0d expected 40", n); end
    checks++; if (keys4[128 +: 32] !== 32'ha0fafe17) begin fails++; $display("FAIL fips_w4: got %h expected a0fafe17", keys4[128 +: 32]); end
    checks++; if (keys4[128 +: 128] !== 128'ha0fafe1788542cb123a339392a6c7605) begin fails++; $display("FAIL fips_round1: got %h expected a0fafe1788542cb123a339392a6c7605", keys4[128 +: 128]); end
    checks++; if (keys4[1376 +: 32] !== 32'hb6630ca6) begin fails++; $display("FAIL fips_w43: got %h expected b6630ca6", keys4[1376 +: 32]); end
    checks++; if (keys4[1280 +: 128] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin fails++; $display("FAIL fips_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", keys4[1280 +: 128]); end
    checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL fips_busy_done: got %b expected 0", busy4); end
  endtask

  task automatic test_restart_from_done;
    int n;
    key4 = SEQ_KEY4;
    pulse(4);
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL restart_valid_drop: got %b expected 0", kv4); end
    wait_valid(4, n);
    checks++; if (n !== 40) begin fails++; $display("FAIL restart_latency: got %0d expected 40", n); end
    checks++; if (keys4[0 +: 128] !== SEQ_KEY4) begin fails++; $display("FAIL restart_round0: got %h expected %h", keys4[0 +: 128], SEQ_KEY4); end
    checks++; if (keys4[1280 +: 128] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin fails++; $display("FAIL restart_round10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", keys4[1280 +: 128]); end
  endtask

  task automatic test_nk6;
    int n;
    key6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    pulse(6);
    wait_valid(6, n);
    checks++; if (n !== 46) begin fails++; $display("FAIL nk6_latency: got %0d expected 46", n); end
    checks++; if (keys6[1536 +: 128] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin fails++; $display("FAIL nk6_round12: got %h expected a4970a331a78dc09c418c271e3a41d5d", keys6[1536 +: 128]); end
  endtask

  task automatic test_nk8;
    int n;
    key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    pulse(8);
    wait_valid(8, n);
    checks++; if (n !== 52) begin fails++; $display("FAIL nk8_latency: got %0d expected 52", n); end
    checks++; if (keys8[1792 +: 128] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin fails++; $display("FAIL nk8_round14: got %h expected 24fc79ccbf0979e9371ac23c6d68de36", keys8[1792 +: 128]); end
  endtask

  task automatic test_start_ignored;
    int n;
    key4 = FIPS_KEY;
    pulse(4);
    n = 0;
    do begin
      @(posedge clks); #1;
      n++;
      if (n == 9) begin
        start4 = 1'b1;
        key4   = 128'h0;
      end else if (n == 10) begin
        start4 = 1'b0;
        checks++; if (busy4 !== 1'b1) begin fails++; $display("FAIL ignored_busy: got %b expected 1", busy4); end
      end else begin
        start4 = 1'b0;
      end
    end while (!kv4 && n < 300);
    checks++; if (n !== 40) begin fails++; $display("FAIL ignored_latency: got %0d expected 40", n); end
    checks++; if (keys4[0 +: 128] !== FIPS_KEY) begin fails++; $display("FAIL ignored_round0: got %h expected %h", keys4[0 +: 128], FIPS_KEY); end
    checks++; if (keys4[1376 +: 32] !== 32'hb6630ca6) begin fails++; $display("FAIL ignored_w43: got %h expected b6630ca6", keys4[1376 +: 32]); end
  endtask

  task automatic test_reset_restart;
    int n;
    key4 = FIPS_KEY;
    pulse(4);
    repeat (20) @(posedge clks);
    #1;
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL abort_early_valid: got %b expected 0", kv4); end
    reset = 1'b1;
    #1;
    checks++; if (busy4 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy4); end
    @(posedge clks); #1 reset = 1'b0;
    repeat (3) @(posedge clks);
    #1;
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL abort_no_valid: got %b expected 0", kv4); end
    key4 = SEQ_KEY4;
    pulse(4);
    wait_valid(4, n);
    checks++; if (n !== 40) begin fails++; $display("FAIL abort_restart_latency: got %0d expected 40", n); end
    checks++; if (keys4[1280 +: 128] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin fails++; $display("FAIL abort_restart_round10: got %h expected 13111d7fe3944a17f307a78b4d2b30c5", keys4[1280 +: 128]); end
  endtask

  task automatic test_back_to_back;
    int n;
    key4 = FIPS_KEY;
    start4 = 1'b1;
    @(posedge clks); #1;
    wait_valid(4, n);
    checks++; if (n !== 40) begin fails++; $display("FAIL held_first_latency: got %0d expected 40", n); end
    @(posedge clks); #1;
    checks++; if (kv4 !== 1'b0) begin fails++; $display("FAIL held_valid_pulse: got %b expected 0", kv4); end
    wait_valid(4, n);
    start4 = 1'b0;
    checks++; if (n !== 40) begin fails++; $display("FAIL held_second_latency: got %0d expected 40", n); end
    @(posedge clks); #1;
    checks++; if (kv4 !== 1'b1) begin fails++; $display("FAIL held_release_valid: got %b expected 1", kv4); end
    checks++; if (keys4[1376 +: 32] !== 32'hb6630ca6) begin fails++; $display("FAIL held_w43: got %h expected b6630ca6", keys4[1376 +: 32]); end
  endtask

  initial begin
    test_reset();
    test_fips_key();
    test_restart_from_done();
    test_nk6();
    test_nk8();
    test_start_ignored();
    test_reset_restart();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
